sort_frame_collector: RTL and testbench
=======================================

Name: sort_frame_collector

Overview:
Upstream stage of the combinational Sort block. Accepts a serial stream of 6-bit numbers over a valid/ready handshake and assembles groups of five into the registered frame in_num0..in_num4 that drives Sort. Samples Sort's combinational out_num one cycle after the frame is complete. Returns it downstream as a registered result with its own valid/ready handshake.

Parameters:
DATA_W, 6, width of each number and of the result
NUM_IN, 5, numbers per frame; fixed by Sort's port count, not intended to change
CNT_W, 3, width of the fill counter; must satisfy 2**CNT_W > NUM_IN

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream number valid
in_data  input  DATA_W  upstream number
in_ready  output  1  collector can accept a number this cycle
in_num0..in_num4  output  DATA_W each  registered frame to Sort; in_num0 = first number accepted
sort_result  input  DATA_W  Sort's out_num, combinational from in_num0..4
out_valid  output  1  result available
out_data  output  DATA_W  registered copy of sort_result
out_ready  input  1  downstream accepts result
frame_cnt  output  8  number of frames completed (result handed off); wraps 255->0

Behaviour:
- Reset (rst=1 at a clk edge):
  - State FILL, fill count 0.
  - in_num0..4 = 0, out_data = 0, out_valid = 0, frame_cnt = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-frame or mid-output discards all partial data; no result is emitted.
- State FILL:
  - in_ready = 1, out_valid = 0.
  - Beat accepted when in_valid && in_ready. Accepted data goes to in_num[count], then count++.
  - On the accept that makes count reach NUM_IN: next state EVAL, count cleared to 0.
  - in_valid=0 cycles leave all state unchanged. Gaps between beats are allowed.
- State EVAL (exactly 1 cycle):
  - in_ready = 0. in_num0..4 are stable and Sort settles.
  - At the end of the cycle out_data <= sort_result, out_valid <= 1; next state OUT.
- State OUT:
  - in_ready = 0. out_valid = 1; out_data and in_num0..4 held stable.
  - On out_valid && out_ready: out_valid <= 0, frame_cnt++, next state FILL.
  - in_ready = 1 the following cycle. There is no same-cycle turnaround; a new beat cannot be accepted in the handoff cycle.
- Latency: 5th accept at edge N; EVAL during cycle N..N+1; out_valid = 1 from edge N+1. With out_ready held at 1, the minimum frame period is 7 cycles (5 FILL + EVAL + OUT).
- in_num registers are never cleared between frames; each is overwritten by the next frame's beat.
- in_data is ignored whenever in_ready = 0; upstream must hold its beat (standard valid/ready).
- Sort is instantiated outside this block. This block only exports in_num0..4 and samples sort_result.
- No X propagation: every output is driven from a register or from the state decode.

Decomposition:
- Shared package sort_pkg:
  - DATA_W = 6 and NUM_IN = 5 constants.
  - typedef logic [DATA_W-1:0] num_t.
  - typedef num_t frame_t [NUM_IN].
  - typedef enum logic [1:0] {FILL, EVAL, OUT} coll_state_t.
- No sub-module: the FSM, counter and registers form one small block.
- A top wrapper (outside this spec) connects sort_frame_collector.in_num* to Sort and Sort.out_num to sort_result.

Test Plan:
- Reset then stream 12,3,45,7,30 back to back, out_ready=1 → in_num0..4 = 12,3,45,7,30 in EVAL; out_valid rises 1 cycle after the 5th accept; out_data equals the Sort golden model output for that frame; frame_cnt=1; in_ready=1 two cycles after the 5th accept.
- Same stream with in_valid gaps of 0–3 random cycles → identical in_num0..4 and out_data; count advances only on accepts.
- out_ready held 0 for 10 cycles in OUT → out_valid and out_data stable, in_ready=0, in_valid=1 with data 63 not accepted; release out_ready → handoff, frame_cnt++, next accepted beat lands in in_num0.
- Assert rst after the 3rd beat (data 1,2,3) → all outputs 0, out_valid never asserted; following frame 63,0,63,0,63 produces a correct result with frame_cnt=1.
- 256 consecutive random frames → each out_data matches the golden Sort model; frame_cnt wraps to 0 after the 256th handoff.
- Boundary values: frame 0,0,0,0,0 and frame 63,63,63,63,63 → out_data 0 and 63 respectively (checked against the golden model); no width truncation.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and constants for the Sort frame collector.
package sort_pkg;

  localparam int unsigned DATA_W = 6;
  localparam int unsigned NUM_IN = 5;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned FCNT_W = 8;

  typedef logic [DATA_W-1:0] num_t;
  typedef num_t frame_t [NUM_IN];

  typedef enum logic [1:0] {FILL, EVAL, OUT} coll_state_t;

endpackage

// File: rtl/sort_frame_collector_if.sv
// Upstream beat and downstream result handshakes of the frame collector.
interface sort_frame_collector_if;
  import sort_pkg::*;

  logic in_valid;
  num_t in_data;
  logic in_ready;
  logic out_valid;
  num_t out_data;
  logic out_ready;

  // Upstream/downstream environment side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Collector side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/sort_frame_collector.sv
// Collects NUM_IN serial numbers into the frame that feeds Sort, samples the
// result one cycle after the frame is complete and hands it downstream.
module sort_frame_collector
  import sort_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  sort_frame_collector_if.slave bus,
  output num_t                  in_num0,
  output num_t                  in_num1,
  output num_t                  in_num2,
  output num_t                  in_num3,
  output num_t                  in_num4,
  input  num_t                  sort_result,
  output logic [FCNT_W-1:0]     frame_cnt
);

  coll_state_t         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  frame_t              frame_q, frame_d;
  num_t                out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                accept_c;

  // State and datapath registers; reset discards any partial frame or result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      frame_q     <= '{default: '0};
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Next-state logic: fill the frame, one settle cycle, then hold the result.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    frame_cnt_d = frame_cnt_q;
    accept_c    = bus.in_valid && (state_q == FILL);

    case (state_q)
      FILL: begin
        if (accept_c) begin
          frame_d[cnt_q] = bus.in_data;
          if (cnt_q == CNT_W'(NUM_IN - 1)) begin
            cnt_d   = '0;
            state_d = EVAL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      EVAL: begin
        out_data_d  = sort_result;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          frame_cnt_d = frame_cnt_q + FCNT_W'(1);
          state_d     = FILL;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase

    // Ready is registered from the next state, so the handoff cycle never accepts.
    in_ready_d = (state_d == FILL);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign in_num0       = frame_q[0];
  assign in_num1       = frame_q[1];
  assign in_num2       = frame_q[2];
  assign in_num3       = frame_q[3];
  assign in_num4       = frame_q[4];
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_sort_frame_collector.sv
// Self-checking bench for sort_frame_collector with a median-of-five Sort stand-in.
module tb_sort_frame_collector;
  import sort_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  num_t       in_num0, in_num1, in_num2, in_num3, in_num4;
  num_t       sort_result;
  logic [7:0] frame_cnt;
  frame_t     dut_f;

  int n_total = 0;
  int n_pass  = 0;

  sort_frame_collector_if bus ();

  sort_frame_collector dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .in_num0     (in_num0),
    .in_num1     (in_num1),
    .in_num2     (in_num2),
    .in_num3     (in_num3),
    .in_num4     (in_num4),
    .sort_result (sort_result),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  // Golden Sort: middle value of the five numbers in ascending order.
  function automatic num_t median5(input frame_t f);
    num_t s [5];
    num_t t;
    for (int i = 0; i < 5; i++) s[i] = f[i];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    return s[2];
  endfunction

  always_comb begin
    dut_f[0] = in_num0;
    dut_f[1] = in_num1;
    dut_f[2] = in_num2;
    dut_f[3] = in_num3;
    dut_f[4] = in_num4;
    sort_result = median5(dut_f);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: beats in the current frame, a pending evaluation,
  // and a held result waiting for the downstream consumer.
  bit     started = 1'b0;
  int     m_nacc;
  frame_t m_frame;
  bit     m_eval;
  bit     m_out_valid;
  int     m_out_data;
  int     m_fcnt;

  always @(posedge clk) begin
    if (rst) begin
      started     = 1'b1;
      m_nacc      = 0;
      for (int i = 0; i < 5; i++) m_frame[i] = '0;
      m_eval      = 1'b0;
      m_out_valid = 1'b0;
      m_out_data  = 0;
      m_fcnt      = 0;
    end else if (started) begin
      if (m_out_valid) begin
        if (bus.out_ready) begin
          m_out_valid = 1'b0;
          m_fcnt      = (m_fcnt + 1) % 256;
        end
      end else if (m_eval) begin
        m_eval      = 1'b0;
        m_out_valid = 1'b1;
        m_out_data  = int'(median5(m_frame));
      end else if (bus.in_valid) begin
        m_frame[m_nacc] = bus.in_data;
        m_nacc++;
        if (m_nacc == 5) begin
          m_nacc = 0;
          m_eval = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", int'(bus.in_ready), int'(!m_eval && !m_out_valid));
      chk("out_valid", int'(bus.out_valid), int'(m_out_valid));
      chk("out_data", int'(bus.out_data), m_out_data);
      chk("frame_cnt", int'(frame_cnt), m_fcnt);
      for (int i = 0; i < 5; i++)
        chk($sformatf("in_num%0d", i), int'(dut_f[i]), int'(m_frame[i]));
    end
  end

  // Present one beat, hold it until accepted; returns at the negedge after acceptance.
  task automatic send(input num_t d, input int gap);
    int guard;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("send_timeout", guard, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int max_gap);
    for (int i = 0; i < 5; i++)
      send(f[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("idle_timeout", guard, 0);
  endtask

  frame_t f;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);

    // Back-to-back frame: median of 12,3,45,7,30 is 12.
    f = '{12, 3, 45, 7, 30};
    send_frame(f, 0);
    chk("f1_in_num0", int'(in_num0), 12);
    chk("f1_in_num2", int'(in_num2), 45);
    chk("f1_in_num4", int'(in_num4), 30);
    chk("f1_eval_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("f1_out_valid", int'(bus.out_valid), 1);
    chk("f1_out_data", int'(bus.out_data), 12);
    chk("f1_out_ready_busy", int'(bus.in_ready), 0);
    @(negedge clk);
    chk("f1_frame_cnt", int'(frame_cnt), 1);
    chk("f1_in_ready_back", int'(bus.in_ready), 1);

    // Same stream with random gaps between beats.
    send_frame(f, 3);
    chk("gap_in_num1", int'(in_num1), 3);
    chk("gap_in_num3", int'(in_num3), 7);
    repeat (2) @(negedge clk);
    chk("gap_out_data", int'(bus.out_data), 12);
    chk("gap_frame_cnt", int'(frame_cnt), 2);

    // Stall the result; a pending upstream beat must not be taken.
    bus.out_ready = 1'b0;
    f = '{5, 60, 33, 18, 41};
    send_frame(f, 0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 6'd63;
    for (int i = 0; i < 10; i++) begin
      if (!bus.out_valid || bus.in_ready || bus.out_data != 6'd33 || in_num0 != 6'd5)
        chk("stall_hold", 0, 1);
      @(negedge clk);
    end
    chk("stall_out_valid", int'(bus.out_valid), 1);
    chk("stall_out_data", int'(bus.out_data), 33);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_frame_cnt", int'(frame_cnt), 3);
    chk("stall_out_valid_low", int'(bus.out_valid), 0);
    send(6'd20, 0);
    chk("stall_next_in_num0", int'(in_num0), 20);
    send(6'd21, 0); send(6'd22, 0); send(6'd23, 0); send(6'd24, 0);
    wait_idle();

    // Reset in the middle of a frame.
    send(6'd1, 0); send(6'd2, 0); send(6'd3, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_num0", int'(in_num0), 0);
    chk("mid_rst_in_num2", int'(in_num2), 0);
    chk("mid_rst_frame_cnt", int'(frame_cnt), 0);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    repeat (3) @(negedge clk);
    chk("mid_rst_no_result", int'(bus.out_valid), 0);
    f = '{63, 0, 63, 0, 63};
    send_frame(f, 0);
    repeat (2) @(negedge clk);
    chk("post_rst_out_data", int'(bus.out_data), 63);
    chk("post_rst_frame_cnt", int'(frame_cnt), 1);

    // Boundary values.
    f = '{0, 0, 0, 0, 0};
    send_frame(f, 0);
    @(negedge clk);
    chk("zero_out_data", int'(bus.out_data), 0);
    @(negedge clk);
    f = '{63, 63, 63, 63, 63};
    send_frame(f, 0);
    @(negedge clk);
    chk("max_out_data", int'(bus.out_data), 63);
    chk("max_in_num4", int'(in_num4), 63);
    @(negedge clk);

    // 256 random frames from reset: frame counter wraps back to 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < 5; i++) f[i] = num_t'($urandom_range(0, 63));
      send_frame(f, 0);
      repeat (2) @(negedge clk);
      if (n == 254) chk("wrap_255", int'(frame_cnt), 255);
    end
    chk("wrap_0", int'(frame_cnt), 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
